// File: rtl/px_adc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | px_adc_pkg : shared types and constants for the pixel ADC emulator |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package px_adc_pkg;

  typedef enum logic [1:0] {
    PAT_RAMP  = 2'd0,
    PAT_CONST = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_LFSR  = 2'd3
  } pat_mode_t;

  localparam int DATA_BITS  = 12;
  localparam int FRAME_BITS = 16;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1 -> bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage : px_adc_pkg
`default_nettype wire

// File: rtl/px_adc_pattern_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | px_adc_pattern_gen : pixel position, LFSR and per-channel samples |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module px_adc_pattern_gen #(
  parameter int DATA_BITS = 12,
  parameter int FRAME_W   = 112,
  parameter int FRAME_H   = 112,
  parameter int CH_OFFSET = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      advance,
  input  logic                      frame_start,
  input  logic [1:0]                mode,
  input  logic [DATA_BITS-1:0]      const_val,
  output logic [3:0][DATA_BITS-1:0] sample
);
  import px_adc_pkg::*;

  localparam int COL_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int ROW_W = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [15:0]      lfsr;
  logic             lfsr_fb;
  logic             check_odd;

  assign lfsr_fb   = ^(lfsr & LFSR_TAPS);
  assign check_odd = col[0] ^ row[0];

  // frame_start wins over a same-cycle advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col  <= '0;
      row  <= '0;
      lfsr <= LFSR_SEED;
    end else if (frame_start) begin
      col  <= '0;
      row  <= '0;
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= {lfsr[14:0], lfsr_fb};
      if (col == COL_W'(FRAME_W - 1)) begin
        col <= '0;
        row <= (row == ROW_W'(FRAME_H - 1)) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_ch
    localparam logic [DATA_BITS-1:0] OFF = DATA_BITS'(k * CH_OFFSET);
    localparam logic [DATA_BITS-1:0] INV = (k % 2 == 1) ? '1 : '0;

    always_comb begin
      sample[k] = '0;
      case (pat_mode_t'(mode))
        PAT_RAMP:  sample[k] = DATA_BITS'(col) + DATA_BITS'(row) + OFF;
        PAT_CONST: sample[k] = const_val;
        PAT_CHECK: sample[k] = (check_odd ? '1 : '0) ^ INV;
        PAT_LFSR:  sample[k] = lfsr[DATA_BITS-1:0] + OFF;
        default:   sample[k] = '0;
      endcase
    end
  end

endmodule : px_adc_pattern_gen
`default_nettype wire

// File: rtl/px_adc_emulator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | px_adc_emulator : four serial pixel ADCs driven by shared CS/SCLK |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module px_adc_emulator #(
  parameter int DATA_BITS  = 12,
  parameter int LEAD_ZEROS = 4,
  parameter int FRAME_W    = 112,
  parameter int FRAME_H    = 112,
  parameter int CH_OFFSET  = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 px_adc_cs,
  input  logic                 px_adc_sclk,
  input  logic [1:0]           pattern_mode,
  input  logic [DATA_BITS-1:0] const_val,
  input  logic                 frame_start,
  output logic                 px0_adc_dout,
  output logic                 px1_adc_dout,
  output logic                 px2_adc_dout,
  output logic                 px3_adc_dout,
  output logic                 busy,
  output logic [15:0]          conv_count,
  output logic                 err_short
);
  import px_adc_pkg::*;

  localparam int SR_W  = LEAD_ZEROS + DATA_BITS;
  localparam int CNT_W = $clog2(SR_W + 1);

  logic [1:0] cs_sync, sclk_sync;
  logic       cs_prev, sclk_prev;
  logic       cs_fall, cs_rise, sclk_fall, cs_low;
  logic       full_frame, advance;

  logic [CNT_W-1:0]           bit_cnt;
  logic [3:0][SR_W-1:0]       shreg;
  logic [3:0][DATA_BITS-1:0]  sample;

  // Both lines idle high, so the synchronizers reset high to avoid phantom edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= 2'b11;
      cs_prev   <= 1'b1;
      sclk_sync <= 2'b11;
      sclk_prev <= 1'b1;
    end else begin
      cs_sync   <= {cs_sync[0], px_adc_cs};
      cs_prev   <= cs_sync[1];
      sclk_sync <= {sclk_sync[0], px_adc_sclk};
      sclk_prev <= sclk_sync[1];
    end
  end

  assign cs_fall    = cs_prev & ~cs_sync[1];
  assign cs_rise    = ~cs_prev & cs_sync[1];
  assign cs_low     = ~cs_sync[1];
  assign sclk_fall  = sclk_prev & ~sclk_sync[1];
  assign full_frame = (bit_cnt >= CNT_W'(SR_W - 1));
  assign advance    = cs_rise & busy & full_frame;

  px_adc_pattern_gen #(
    .DATA_BITS (DATA_BITS),
    .FRAME_W   (FRAME_W),
    .FRAME_H   (FRAME_H),
    .CH_OFFSET (CH_OFFSET)
  ) u_pattern_gen (
    .clk         (clk),
    .reset       (reset),
    .advance     (advance),
    .frame_start (frame_start),
    .mode        (pattern_mode),
    .const_val   (const_val),
    .sample      (sample)
  );

  // A CS fall always reloads, even if the previous conversion never saw a rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      busy       <= 1'b0;
      conv_count <= '0;
      err_short  <= 1'b0;
    end else begin
      err_short <= 1'b0;
      if (cs_fall) begin
        for (int k = 0; k < 4; k++) begin
          shreg[k] <= {{LEAD_ZEROS{1'b0}}, sample[k]};
        end
        bit_cnt <= '0;
        busy    <= 1'b1;
      end else if (cs_rise && busy) begin
        busy  <= 1'b0;
        shreg <= '0;
        if (full_frame) begin
          conv_count <= conv_count + 16'd1;
        end else begin
          err_short <= 1'b1;
        end
      end else if (sclk_fall && cs_low && busy && (bit_cnt < CNT_W'(SR_W))) begin
        for (int k = 0; k < 4; k++) begin
          shreg[k] <= {shreg[k][SR_W-2:0], 1'b0};
        end
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  assign px0_adc_dout = shreg[0][SR_W-1];
  assign px1_adc_dout = shreg[1][SR_W-1];
  assign px2_adc_dout = shreg[2][SR_W-1];
  assign px3_adc_dout = shreg[3][SR_W-1];

endmodule : px_adc_emulator
`default_nettype wire

// File: tb/tb_px_adc_emulator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_px_adc_emulator : directed checks of the pixel ADC emulator    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_px_adc_emulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        sclk;
  logic [1:0]  mode;
  logic [11:0] const_val;
  logic        frame_start;
  wire         d0, d1, d2, d3;
  wire         busy;
  wire  [15:0] conv_count;
  wire         err_short;
  wire  [3:0]  dout = {d3, d2, d1, d0};

  int tests   = 0;
  int fails   = 0;
  int err_cnt = 0;
  int exp_cnt = 0;

  logic [15:0] word [4];
  logic [3:0]  tail;
  logic        busy_seen;

  px_adc_emulator #(
    .DATA_BITS  (12),
    .LEAD_ZEROS (4),
    .FRAME_W    (4),
    .FRAME_H    (2),
    .CH_OFFSET  (256)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .px_adc_cs    (cs),
    .px_adc_sclk  (sclk),
    .pattern_mode (mode),
    .const_val    (const_val),
    .frame_start  (frame_start),
    .px0_adc_dout (d0),
    .px1_adc_dout (d1),
    .px2_adc_dout (d2),
    .px3_adc_dout (d3),
    .busy         (busy),
    .conv_count   (conv_count),
    .err_short    (err_short)
  );

  always #5 clk = ~clk;

  // Counts high cycles of err_short so a stretched pulse shows up as >1
  always @(posedge clk) if (err_short) err_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sclk_cycle();
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_fs();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  // One conversion: bit 15 is read before the first fall, bits 14..0 after falls 1..15
  task automatic conv(input int nfalls, input bit fs_at_rise);
    @(negedge clk) cs = 1'b0;
    repeat (6) @(negedge clk);
    busy_seen = busy;
    for (int k = 0; k < 4; k++) word[k] = '0;
    for (int k = 0; k < 4; k++) word[k][15] = dout[k];
    tail = 'x;
    for (int i = 1; i <= nfalls; i++) begin
      sclk_cycle();
      if (i <= 15) begin
        for (int k = 0; k < 4; k++) word[k][15-i] = dout[k];
      end else begin
        tail = dout;
      end
    end
    cs = 1'b1;
    if (fs_at_rise) begin
      @(negedge clk);
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
    end
    repeat (6) @(negedge clk);
    if (nfalls >= 15) exp_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; cs = 1'b1; sclk = 1'b1; mode = 2'd0;
    const_val = 12'h000; frame_start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dout",  {28'd0, dout}, 32'h0);
    check("reset_busy",  {31'd0, busy}, 32'h0);
    check("reset_count", {16'd0, conv_count}, 32'h0);
    check("reset_err",   {31'd0, err_short}, 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Ramp, 4x2 frame
    conv(16, 1'b0);
    check("ramp1_ch0",  {16'd0, word[0]}, 32'h0000);
    check("ramp1_ch1",  {16'd0, word[1]}, 32'h0100);
    check("ramp1_ch2",  {16'd0, word[2]}, 32'h0200);
    check("ramp1_ch3",  {16'd0, word[3]}, 32'h0300);
    check("ramp1_busy_during", {31'd0, busy_seen}, 32'h1);
    check("ramp1_tail_idle",   {28'd0, tail}, 32'h0);
    check("ramp1_busy_after",  {31'd0, busy}, 32'h0);
    check("ramp1_count",       {16'd0, conv_count}, 32'd1);
    for (int n = 2; n <= 5; n++) conv(16, 1'b0);
    conv(16, 1'b0);
    check("ramp6_ch0", {16'd0, word[0]}, 32'h0002);
    check("ramp6_ch3", {16'd0, word[3]}, 32'h0302);
    conv(16, 1'b0);
    conv(16, 1'b0);
    conv(16, 1'b0);
    check("ramp9_ch0",   {16'd0, word[0]}, 32'h0000);
    check("ramp9_ch1",   {16'd0, word[1]}, 32'h0100);
    check("ramp9_count", {16'd0, conv_count}, 32'd9);

    // Constant
    mode = 2'd1; const_val = 12'hA5C;
    conv(16, 1'b0);
    for (int k = 0; k < 4; k++) check($sformatf("const_ch%0d", k), {16'd0, word[k]}, 32'h0A5C);
    check("const_tail_idle", {28'd0, tail}, 32'h0);

    // Checkerboard
    mode = 2'd2;
    pulse_fs();
    conv(16, 1'b0);
    check("check_p0_ch0", {16'd0, word[0]}, 32'h0000);
    check("check_p0_ch1", {16'd0, word[1]}, 32'h0FFF);
    conv(16, 1'b0);
    check("check_p1_ch0", {16'd0, word[0]}, 32'h0FFF);
    check("check_p1_ch1", {16'd0, word[1]}, 32'h0000);

    // LFSR: seed ACE1, next state 59C3
    mode = 2'd3;
    pulse_fs();
    conv(16, 1'b0);
    check("lfsr0_ch0", {16'd0, word[0]}, 32'h0CE1);
    check("lfsr0_ch1", {16'd0, word[1]}, 32'h0DE1);
    conv(16, 1'b0);
    check("lfsr1_ch0", {16'd0, word[0]}, 32'h09C3);
    check("lfsr1_ch3", {16'd0, word[3]}, 32'h0CC3);

    // Aborted conversion after 8 falls at pixel (0,1)
    mode = 2'd0;
    pulse_fs();
    conv(16, 1'b0);
    conv(8, 1'b0);
    check("abort_err_pulse", err_cnt, 32'd1);
    check("abort_count",     {16'd0, conv_count}, exp_cnt);
    check("abort_busy",      {31'd0, busy}, 32'h0);
    check("abort_dout",      {28'd0, dout}, 32'h0);
    conv(16, 1'b0);
    check("abort_repeat_ch0", {16'd0, word[0]}, 32'h0001);
    check("abort_repeat_ch2", {16'd0, word[2]}, 32'h0201);

    // Reset in the middle of bit 7; pixel was (0,2)
    @(negedge clk) cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 7; i++) sclk_cycle();
    check("midreset_busy_before", {31'd0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    check("midreset_dout",  {28'd0, dout}, 32'h0);
    check("midreset_busy",  {31'd0, busy}, 32'h0);
    check("midreset_count", {16'd0, conv_count}, 32'h0);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
    repeat (6) @(negedge clk);
    check("midreset_no_err", err_cnt, 32'd1);
    conv(16, 1'b0);
    check("postreset_ch0",   {16'd0, word[0]}, 32'h0000);
    check("postreset_count", {16'd0, conv_count}, exp_cnt);

    // frame_start coincident with the completing CS rise at pixel (0,1)
    conv(16, 1'b1);
    check("fsrise_ch0",  {16'd0, word[0]}, 32'h0001);
    check("fsrise_count", {16'd0, conv_count}, exp_cnt);
    conv(16, 1'b0);
    check("fsrise_next_ch0", {16'd0, word[0]}, 32'h0000);
    check("fsrise_next_ch3", {16'd0, word[3]}, 32'h0300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_px_adc_emulator
`default_nettype wire

// File: doc/px_adc_emulator.md
Name: px_adc_emulator

Overview:
- Synthesizable stand-in for the four serial pixel ADCs read by the imaging block's ADC front end.
- Responds to the shared chip-select and serial clock from the imaging block and drives four serial data lines with deterministic test patterns.
- Used for on-fabric loopback of the capture path, APB readout and frame FIFO without a sensor attached.
- Frame format per conversion: 4 leading zeros followed by 12 data bits, MSB first.

Parameters:
- DATA_BITS, 12, sample width
- LEAD_ZEROS, 4, leading zero bits per conversion (frame = 16 bits)
- FRAME_W, 112, pixels per row
- FRAME_H, 112, rows per frame
- CH_OFFSET, 256, per-channel additive offset in ramp/LFSR modes

Ports:
- clk  in  1  system clock; must be at least 4x px_adc_sclk frequency
- reset  in  1  asynchronous, active-high reset
- px_adc_cs  in  1  active-low chip select from the imaging block
- px_adc_sclk  in  1  serial clock from the imaging block; idles high
- pattern_mode  in  2  0 ramp, 1 constant, 2 checkerboard, 3 LFSR
- const_val  in  12  sample value for constant mode
- frame_start  in  1  one-clk pulse; restarts the pattern at pixel (0,0)
- px0_adc_dout .. px3_adc_dout  out  1 each  serial data to channels 0..3
- busy  out  1  high while a conversion frame is in progress
- conv_count  out  16  completed-conversion counter
- err_short  out  1  one-clk pulse on an aborted conversion

Behaviour:
- Reset values: all dout 0, busy 0, conv_count 0, err_short 0, row=col=0, LFSR=16'hACE1, bit_cnt 0.
- px_adc_cs and px_adc_sclk pass through 2-flop synchronizers; edges are detected on the synchronized copies.
- CS fall:
  - latch pattern_mode, const_val, row, col and LFSR state;
  - load channel k shift register with {4'b0, sample_k};
  - bit_cnt=0, busy=1;
  - each dout drives bit 15 of its shift register.
- SCLK fall with CS low and bit_cnt<15: shift left, bit_cnt++, dout = new bit 15.
- SCLK fall with bit_cnt=15: bit_cnt=16 and dout=0 (bus idle). Further falls are ignored.
- Latency: dout changes 3 clk after the physical edge (2 sync + 1 register). The imaging block samples on SCLK rise.
- CS rise with bit_cnt>=15 (all 16 bits presented): conversion complete.
  - busy=0;
  - conv_count++ (wraps 65535->0);
  - col++; at FRAME_W-1, col wraps to 0 and row++; at FRAME_H-1, row wraps to 0;
  - LFSR advances one step (x^16+x^14+x^13+x^11+1, Fibonacci, shift left).
- CS rise with bit_cnt<15: abort.
  - err_short=1 for 1 clk, busy=0, dout=0;
  - no counter, pixel or LFSR advance.
- Sample formulas, all mod 2^12, k = channel index:
  - ramp: sample_k = col + row + k*CH_OFFSET;
  - constant: sample_k = const_val for all k;
  - checkerboard: base = (col^row)[0] ? 12'hFFF : 12'h000; odd k inverted;
  - LFSR: sample_k = lfsr[11:0] + k*CH_OFFSET.
- frame_start:
  - sets row=col=0 and LFSR=16'hACE1;
  - takes priority over a same-cycle conversion-complete advance (conv_count still increments);
  - during a conversion it does not alter the frame already loaded.
- pattern_mode and const_val changes mid-conversion have no effect until the next CS fall.
- SCLK edges while CS high are ignored.
- CS fall while busy (no rise seen) is treated as a new conversion: reload, no abort pulse.
- Reset asserted mid-conversion immediately forces all reset values.

Decomposition:
- Package px_adc_pkg holds:
  - pattern mode enum (PAT_RAMP, PAT_CONST, PAT_CHECK, PAT_LFSR);
  - DATA_BITS and FRAME_BITS=16;
  - LFSR_SEED=16'hACE1 and the tap mask.
- Sub-module px_adc_pattern_gen owns row/col counters, the LFSR, frame_start handling and the four sample_k computations. Inputs: advance pulse, frame_start, mode, const_val.
- The top level holds synchronizers, edge detection, bit counter, shift registers, busy/err/count.

Test Plan:
- Ramp, FRAME_W=4, FRAME_H=2, CH_OFFSET=256, sclk = clk/8:
  - conversion 1 -> ch0 0x000, ch1 0x100, ch2 0x200, ch3 0x300, 4 leading zeros;
  - conversion 6 (row1, col1) -> ch0 0x002, ch3 0x302;
  - conversion 9 wraps to 0x000; conv_count=9.
- Constant const_val=0xA5C -> all channels shift 0000_1010_0101_1100; dout=0 after the 16th SCLK fall.
- Checkerboard at (0,0) then (1,0) -> ch0 0x000 then 0xFFF; ch1 0xFFF then 0x000.
- LFSR after frame_start -> ch0 = 0xCE1, ch1 = 0xDE1; next conversion uses the advanced LFSR.
- CS raised after 8 SCLK falls:
  - err_short 1-clk pulse;
  - conv_count and pixel unchanged;
  - next conversion repeats the same sample.
- Reset at bit 7 -> dout 0, busy 0, conv_count 0; next conversion yields pixel (0,0). frame_start coincident with CS rise -> next sample is pixel (0,0).
